// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the fetch and data requesters.
// Data has fixed priority. A starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants while a fetch is waiting.
// The physical port is driven only from registers latched at grant time.
module mem_port_arbiter #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // fetch side
  input  logic             i_read,
  input  logic [WIDTH-1:0] i_address,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_resp,
  // data side
  input  logic             d_read,
  input  logic             d_write,
  input  logic [1:0]       d_byte_enable,
  input  logic [WIDTH-1:0] d_address,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_resp,
  // physical port
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [1:0]       pmem_byte_enable,
  output logic [WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp,
  output logic             busy
);

  // Counter width must hold STARVE_LIMIT; keep at least one bit when disabled.
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIGrant, StDGrant} state_e;

  state_e           state_q;
  logic [CntW-1:0]  starve_cnt_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [1:0]       be_q;
  logic             read_q;
  logic             write_q;

  logic d_req;
  logic starved;

  // Request decode: a waiting fetch that hit the limit outranks data.
  always_comb begin
    d_req   = d_read | d_write;
    starved = (STARVE_LIMIT != 0) && i_read && (starve_cnt_q >= Limit);
  end

  // Arbitration FSM with latched transaction and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_req && !starved) begin
            state_q <= StDGrant;
            addr_q  <= d_address;
            wdata_q <= d_wdata;
            be_q    <= d_byte_enable;
            // Read+write together resolves to a write.
            read_q  <= ~d_write;
            write_q <= d_write;
            if (!i_read) begin
              starve_cnt_q <= '0;
            end else if (starve_cnt_q < Limit) begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end else if (i_read) begin
            state_q      <= StIGrant;
            addr_q       <= i_address;
            wdata_q      <= '0;
            be_q         <= 2'b11;
            read_q       <= 1'b1;
            write_q      <= 1'b0;
            starve_cnt_q <= '0;
          end else begin
            starve_cnt_q <= '0;
          end
        end
        StIGrant, StDGrant: begin
          // Requester inputs are ignored here; only the memory ends a grant.
          if (pmem_resp) begin
            state_q <= StIdle;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Port outputs come straight from registers; resp is gated by the grant.
  always_comb begin
    pmem_read        = read_q;
    pmem_write       = write_q;
    pmem_byte_enable = be_q;
    pmem_address     = addr_q;
    pmem_wdata       = wdata_q;
    busy             = (state_q != StIdle);
    i_resp           = (state_q == StIGrant) && pmem_resp;
    d_resp           = (state_q == StDGrant) && pmem_resp;
    i_rdata          = pmem_rdata;
    d_rdata          = pmem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int W   = 16;
  localparam int LIM = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [W-1:0] i_address;
  logic [W-1:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [1:0]   d_byte_enable;
  logic [W-1:0] d_address;
  logic [W-1:0] d_wdata;
  logic [W-1:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [1:0]   pmem_byte_enable;
  logic [W-1:0] pmem_address;
  logic [W-1:0] pmem_wdata;
  logic [W-1:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WIDTH       (W),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_read          (i_read),
    .i_address       (i_address),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byte_enable   (d_byte_enable),
    .d_address       (d_address),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .busy            (busy)
  );

  int tests = 0;
  int fails = 0;

  // Model: which side owns the port (0 none, 1 fetch, 2 data), the latched
  // transaction, consecutive data wins while fetch waits, cycles in grant.
  int         m_grant  = 0;
  logic [W-1:0] m_addr = '0;
  logic [W-1:0] m_wdata = '0;
  logic [1:0] m_be     = '0;
  logic       m_write  = 1'b0;
  int         m_starve = 0;
  int         m_age    = 0;
  logic       e_i_resp = 1'b0;
  logic       e_d_resp = 1'b0;
  int         resp_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit starved;
    if (!rst_n) begin
      m_grant = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_write = 1'b0;
      m_starve = 0; m_age = 0;
    end else if (m_grant == 0) begin
      starved = (LIM != 0) && i_read && (m_starve >= LIM);
      if ((d_read || d_write) && !starved) begin
        m_grant = 2; m_addr = d_address; m_wdata = d_wdata; m_be = d_byte_enable;
        m_write = d_write; m_age = 0;
        m_starve = i_read ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      end else if (i_read) begin
        m_grant = 1; m_addr = i_address; m_wdata = '0; m_be = 2'b11;
        m_write = 1'b0; m_age = 0; m_starve = 0;
      end else begin
        m_starve = 0;
      end
    end else if (pmem_resp) begin
      m_grant = 0;
    end else begin
      m_age++;
    end
  endtask

  // Compare all meaningful outputs against the model, mid-cycle.
  task automatic sample();
    #1;
    e_i_resp = (m_grant == 1) && pmem_resp;
    e_d_resp = (m_grant == 2) && pmem_resp;
    chk("busy", busy, m_grant != 0);
    chk("pmem_read", pmem_read, (m_grant != 0) && !m_write);
    chk("pmem_write", pmem_write, (m_grant != 0) && m_write);
    if (m_grant != 0) begin
      chk("pmem_address", pmem_address, m_addr);
      chk("pmem_byte_enable", pmem_byte_enable, m_be);
      if (m_write) chk("pmem_wdata", pmem_wdata, m_wdata);
    end
    chk("i_resp", i_resp, e_i_resp);
    chk("d_resp", d_resp, e_d_resp);
    if (e_i_resp) chk("i_rdata", i_rdata, pmem_rdata);
    if (e_d_resp) chk("d_rdata", d_rdata, pmem_rdata);
    if (i_resp) resp_log.push_back(1);
    if (d_resp) resp_log.push_back(2);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_byte_enable = '0; d_address = '0; d_wdata = '0;
    pmem_resp = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int k = 0; k < n; k++) begin
      sample();
      edge_step();
    end
  endtask

  initial begin
    int   exp3[6];
    int   wseen;
    int   dcyc;
    int   rcyc;
    int   dcount;
    logic [1:0] wbe;
    bit   i_pend;
    bit   d_pend;
    int   kind;

    rst_n = 1'b0;
    idle_inputs();
    pmem_rdata = '0;
    @(negedge clk);
    edge_step();
    edge_step();

    // Reset state
    sample();
    chk("rst_busy", busy, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_be", pmem_byte_enable, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    rst_n = 1'b1;
    edge_step();

    // Single fetch
    i_read = 1'b1; i_address = 16'h3000;
    sample(); chk("f_c0_read", pmem_read, 0); edge_step();
    sample(); chk("f_c1_read", pmem_read, 1); chk("f_c1_addr", pmem_address, 16'h3000);
    edge_step();
    sample(); edge_step();
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    sample(); chk("f_c3_iresp", i_resp, 1); chk("f_c3_rdata", i_rdata, 16'h1234);
    edge_step();
    i_read = 1'b0; pmem_resp = 1'b0;
    sample(); chk("f_c4_read", pmem_read, 0); chk("f_c4_busy", busy, 0);
    edge_step();
    idle_cycles(2);

    // Collision: data write wins, then one idle cycle, then the fetch
    resp_log.delete();
    wseen = 0; wbe = '0; dcyc = -1; rcyc = -1;
    i_read = 1'b1; i_address = 16'h3000;
    d_write = 1'b1; d_address = 16'h4001; d_wdata = 16'h00AB; d_byte_enable = 2'b10;
    for (int k = 0; k < 20; k++) begin
      pmem_resp = (m_grant != 0) && (m_age == 2);
      pmem_rdata = 16'(16'h1000 + k);
      sample();
      if (pmem_write && wseen == 0) begin wseen = 1; wbe = pmem_byte_enable; end
      if (d_resp && dcyc < 0) dcyc = k;
      if (pmem_read && rcyc < 0) rcyc = k;
      if (e_d_resp) d_write = 1'b0;
      if (e_i_resp) i_read = 1'b0;
      edge_step();
    end
    chk("coll_write_seen", wseen, 1);
    chk("coll_write_be", wbe, 2'b10);
    chk("coll_resp_count", resp_log.size(), 2);
    if (resp_log.size() >= 2) begin
      chk("coll_first_d", resp_log[0], 2);
      chk("coll_then_i", resp_log[1], 1);
    end
    chk("coll_gap", rcyc - dcyc, 2);
    idle_cycles(2);

    // Starvation with limit 2: both requesters held continuously
    resp_log.delete();
    exp3 = '{2, 2, 1, 2, 2, 1};
    i_read = 1'b1; i_address = 16'h3000;
    d_read = 1'b1; d_address = 16'h5000;
    for (int k = 0; k < 40; k++) begin
      pmem_resp = (m_grant != 0) && (m_age == 1);
      pmem_rdata = 16'($urandom);
      sample();
      edge_step();
    end
    chk("starve_len_ok", resp_log.size() >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      if (k < resp_log.size()) chk($sformatf("starve_order_%0d", k), resp_log[k], exp3[k]);
    end
    idle_cycles(2);

    // Withdrawal mid-grant still completes the latched transaction
    resp_log.delete();
    dcount = 0;
    d_read = 1'b1; d_address = 16'h5000;
    sample(); edge_step();
    sample(); chk("wd_c1_addr", pmem_address, 16'h5000); edge_step();
    d_read = 1'b0; d_address = 16'h6000;
    sample(); chk("wd_c2_addr", pmem_address, 16'h5000); chk("wd_c2_read", pmem_read, 1);
    edge_step();
    sample(); chk("wd_c3_addr", pmem_address, 16'h5000); edge_step();
    pmem_resp = 1'b1;
    sample(); chk("wd_c4_dresp", d_resp, 1); edge_step();
    pmem_resp = 1'b0;
    sample(); chk("wd_c5_busy", busy, 0); edge_step();
    foreach (resp_log[k]) if (resp_log[k] == 2) dcount++;
    chk("wd_one_pulse", dcount, 1);
    idle_cycles(2);

    // Read+write conflict resolves to a write
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h7000; d_wdata = 16'hBEEF;
    d_byte_enable = 2'b11;
    sample(); edge_step();
    pmem_resp = 1'b1;
    sample();
    chk("rw_write", pmem_write, 1); chk("rw_read", pmem_read, 0);
    chk("rw_wdata", pmem_wdata, 16'hBEEF); chk("rw_dresp", d_resp, 1);
    edge_step();
    idle_cycles(2);

    // Reset during a data grant abandons it silently
    d_read = 1'b1; d_address = 16'h5000;
    sample(); edge_step();
    sample(); chk("rg_busy_before", busy, 1); edge_step();
    rst_n = 1'b0;
    sample(); edge_step();
    rst_n = 1'b1; d_read = 1'b0; pmem_resp = 1'b1;
    sample();
    chk("rg_read", pmem_read, 0); chk("rg_write", pmem_write, 0);
    chk("rg_dresp", d_resp, 0); chk("rg_busy", busy, 0);
    edge_step();
    idle_cycles(2);

    // Randomized traffic against the model
    i_pend = 1'b0; d_pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_pend && ($urandom_range(0, 3) == 0)) begin
        i_pend = 1'b1; i_address = 16'($urandom);
      end
      if (i_pend && m_grant == 1 && ($urandom_range(0, 9) == 0)) i_pend = 1'b0;
      i_read = i_pend;
      if (!i_pend) i_address = 16'($urandom);

      if (!d_pend && ($urandom_range(0, 2) == 0)) begin
        d_pend = 1'b1;
        kind = $urandom_range(0, 2);
        d_read = (kind != 1); d_write = (kind != 0);
        d_address = 16'($urandom); d_wdata = 16'($urandom);
        d_byte_enable = 2'($urandom);
      end
      if (d_pend && m_grant == 2 && ($urandom_range(0, 7) == 0)) d_pend = 1'b0;
      if (!d_pend) begin
        d_read = 1'b0; d_write = 1'b0;
        d_address = 16'($urandom); d_wdata = 16'($urandom);
      end

      pmem_resp  = ($urandom_range(0, 2) == 0);
      pmem_rdata = 16'($urandom);
      rst_n      = ($urandom_range(0, 249) != 0);
      sample();
      if (e_i_resp) i_pend = 1'b0;
      if (e_d_resp) d_pend = 1'b0;
      edge_step();
    end
    rst_n = 1'b1;
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single physical memory port between the instruction-fetch side and the data side of the LC-3b core.
- Arbitrates between the two requesters.
- Latches the winning request and drives the physical port from registers.
- Routes the response back to the requester that was granted.
- Fixed data-side priority, with a starvation counter that guarantees fetch progress.

Parameters:
WIDTH, 16, data and address width in bits (LC-3b word).
STARVE_LIMIT, 4, number of consecutive data grants allowed while a fetch waits; 0 disables starvation protection.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active low
i_read  in  1  fetch read request, level, held until i_resp
i_address  in  WIDTH  fetch address
i_rdata  out  WIDTH  fetch read data (= pmem_rdata)
i_resp  out  1  one-cycle completion pulse to fetch side
d_read  in  1  data read request, level
d_write  in  1  data write request, level
d_byte_enable  in  2  byte lanes for write ([0] low byte, [1] high byte)
d_address  in  WIDTH  data address
d_wdata  in  WIDTH  data write data
d_rdata  out  WIDTH  data read data (= pmem_rdata)
d_resp  out  1  one-cycle completion pulse to data side
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_byte_enable  out  2  physical byte lanes
pmem_address  out  WIDTH  physical address
pmem_wdata  out  WIDTH  physical write data
pmem_rdata  in  WIDTH  physical read data
pmem_resp  in  1  physical completion pulse
busy  out  1  high in I_GRANT or D_GRANT

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE; starve_cnt = 0.
  - Latched address, wdata, byte_enable and op registers cleared.
  - All outputs 0 except i_rdata/d_rdata, which follow pmem_rdata.
- States: IDLE, I_GRANT, D_GRANT.
- IDLE arbitration, evaluated every cycle:
  - If d_read or d_write is high and not starved: go to D_GRANT.
  - Else if i_read is high: go to I_GRANT.
  - Else: stay in IDLE.
  - Starved means STARVE_LIMIT != 0, i_read = 1 and starve_cnt >= STARVE_LIMIT; a starved fetch is granted ahead of data.
- Latching at grant:
  - On the IDLE->grant edge, the winner's address, wdata, byte_enable and op are latched.
  - Fetch grants latch op = read and byte_enable = 2'b11.
  - If d_read and d_write are both high, the operation is a write.
- Latency: request seen in IDLE at cycle N; pmem_read/pmem_write asserted from cycle N+1.
- Physical port outputs:
  - pmem_* are driven only from the latched registers.
  - pmem_read/pmem_write are 0 in IDLE.
- Grant states:
  - Hold until pmem_resp = 1.
  - In that same cycle, i_resp or d_resp (for the granted side only) is asserted combinationally.
  - Next state is IDLE.
  - There is exactly one IDLE cycle between back-to-back transactions.
- Request handling:
  - Requester inputs are ignored while in a grant state.
  - Withdrawing a request mid-grant does not abort: the latched transaction completes and the resp pulse is still issued.
  - Requesters must hold their request until resp.
- pmem_resp in IDLE is ignored: no resp pulse and no state change.
- starve_cnt update:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while i_read = 1.
  - Clears to 0 on any I grant.
  - Clears to 0 when i_read = 0 in IDLE.
- Reset mid-transaction:
  - Returns to IDLE at that edge and pmem strobes drop the next cycle.
  - No resp is issued for the abandoned transaction.
- i_rdata and d_rdata are valid only in the cycle of the matching resp.

Test Plan:
1. Single fetch:
   - Stimulus: i_read = 1, i_address = 0x3000 at cycle 0; pmem_resp = 1 with pmem_rdata = 0x1234 at cycle 3.
   - Response: pmem_read = 1 with pmem_address = 0x3000 from cycle 1; i_resp = 1 and i_rdata = 0x1234 at cycle 3; IDLE with pmem_read = 0 at cycle 4.
2. Collision:
   - Stimulus: i_read and d_write (address 0x4001, wdata 0x00AB, byte_enable 2'b10) both raised at cycle 0; memory responds 2 cycles after each strobe.
   - Response: pmem_write with pmem_byte_enable = 2'b10 first; d_resp; one IDLE cycle; then pmem_read at 0x3000; i_resp.
3. Starvation (STARVE_LIMIT = 2):
   - Stimulus: d_read held continuously; i_read held.
   - Response: grant order D, D, I, D, D, I; starve_cnt reads 0 after each I grant.
4. Withdrawal:
   - Stimulus: d_read at address 0x5000 granted; d_read dropped and d_address changed to 0x6000 in cycle 2.
   - Response: pmem_address stays 0x5000 until pmem_resp; d_resp pulses once.
5. Read+write conflict:
   - Stimulus: d_read = d_write = 1.
   - Response: pmem_write = 1 and pmem_read = 0.
6. Reset mid-grant:
   - Stimulus: rst_n = 0 for one edge during D_GRANT; pmem_resp = 1 after reset.
   - Response: pmem_read/pmem_write = 0; no d_resp; busy = 0.
